fetch_if_id_stage: RTL

Fetch stage and IF/ID pipeline register for the dual-issue 16-bit core. Holds the PC, presents a fetch address to the instruction ROM, and latches the two fetched instructions into IF/ID. It obeys the hazard unit's `PCWrite`/`IF_ID_Write` stall controls and flushes on a taken branch resolved in ID. It also extracts the register fields that the hazard unit compares.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/pc_unit.sv | 39 +++
 rtl/fetch_if_id_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the fetch stage and the hazard unit: NOP, FSM encoding, field positions.
// Latency: none (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    // All-zero word is the architectural no-op inserted as a pipeline bubble.
    localparam logic [15:0] NOP = 16'h0000;

    // Two instruction slots are fetched per cycle, so the PC advances by two.
    localparam int PC_STEP = 2;

    // Register-field geometry; the hazard unit compares the same bit ranges.
    localparam int FIELD_W = 3;
    localparam int RD_LSB  = 0;   // Rd / Rd_1 = [2:0]
    localparam int RN_LSB  = 3;   // Rn        = [5:3]
    localparam int RM_LSB  = 6;   // Rm        = [8:6]
    localparam int RD2_LSB = 8;   // Rd_2      = [10:8]

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_FLUSH = 2'd3
    } fetch_state_t;

    // Extract one 3-bit register field starting at bit position lsb.
    function automatic logic [FIELD_W-1:0] get_field(input logic [15:0] inst, input int lsb);
        return inst[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter with next-PC selection: hold, branch redirect, or advance by one slot pair.
// Latency: 1 cycle from control inputs to the registered PC.
// Backpressure: pc_write=0 holds the PC; a hold wins over a pending branch redirect.
module pc_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_next;

    // Next-PC mux; the add wraps modulo 2^PC_W by truncation.
    always_comb begin
        pc_next = pc + PC_W'(PC_STEP);
        if (!pc_write) begin
            pc_next = pc;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end
    end

    // PC register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_if_id_stage.sv
// Dual-issue fetch stage and IF/ID register, with hazard-driven stall/flush and field decode.
// Latency: 1 cycle from PC to IF/ID; taken branch costs exactly one bubble.
// Backpressure: PCWrite/IF_ID_Write=0 freeze PC and IF/ID independently; stall beats branch.
module fetch_if_id_stage
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INST_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PCWrite,
    input  logic              IF_ID_Write,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_inst1,
    input  logic [INST_W-1:0] imem_inst2,
    output logic [PC_W-1:0]   IF_ID_pc,
    output logic [INST_W-1:0] IF_ID_inst1,
    output logic [INST_W-1:0] IF_ID_inst2,
    output logic              IF_ID_valid,
    output logic [2:0]        IF_ID_inst1_Rm,
    output logic [2:0]        IF_ID_inst1_Rd_1,
    output logic [2:0]        IF_ID_inst1_Rd_2,
    output logic [2:0]        IF_ID_inst2_Rm,
    output logic [2:0]        IF_ID_inst2_Rn,
    output logic [2:0]        IF_ID_inst2_Rd,
    output logic [1:0]        fetch_state,
    output logic [15:0]       stall_count
);

    logic [PC_W-1:0] pc;
    logic            flush;
    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [15:0]     inst1_w;
    logic [15:0]     inst2_w;

    pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (PCWrite),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc)
    );

    // ROM address is the PC register itself, so it only moves at clock edges.
    assign imem_addr = pc;

    // A flush squashes the wrong-path fetch only when both the PC redirects and IF/ID is writable.
    assign flush = IF_ID_Write && branch_taken && PCWrite;

    // IF/ID pipeline register: hold on stall, bubble on flush, otherwise capture the fetched pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            IF_ID_pc    <= '0;
            IF_ID_inst1 <= INST_W'(NOP);
            IF_ID_inst2 <= INST_W'(NOP);
            IF_ID_valid <= 1'b0;
        end else if (IF_ID_Write) begin
            if (branch_taken && PCWrite) begin
                IF_ID_pc    <= '0;
                IF_ID_inst1 <= INST_W'(NOP);
                IF_ID_inst2 <= INST_W'(NOP);
                IF_ID_valid <= 1'b0;
            end else begin
                IF_ID_pc    <= pc;
                IF_ID_inst1 <= imem_inst1;
                IF_ID_inst2 <= imem_inst2;
                IF_ID_valid <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: boot always leaves to RUN, then stall takes priority over flush.
    always_comb begin
        state_d = S_RUN;
        if (state_q == S_BOOT) begin
            state_d = S_RUN;
        end else if (!IF_ID_Write) begin
            state_d = S_STALL;
        end else if (flush) begin
            state_d = S_FLUSH;
        end
    end

    assign fetch_state = state_q;

    // Saturating count of stalled cycles since reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (!IF_ID_Write && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    // Field decode reads the registered IF/ID words, never the live ROM data.
    assign inst1_w = 16'(IF_ID_inst1);
    assign inst2_w = 16'(IF_ID_inst2);

    assign IF_ID_inst1_Rm   = get_field(inst1_w, RM_LSB);
    assign IF_ID_inst1_Rd_1 = get_field(inst1_w, RD_LSB);
    assign IF_ID_inst1_Rd_2 = get_field(inst1_w, RD2_LSB);
    assign IF_ID_inst2_Rm   = get_field(inst2_w, RM_LSB);
    assign IF_ID_inst2_Rn   = get_field(inst2_w, RN_LSB);
    assign IF_ID_inst2_Rd   = get_field(inst2_w, RD_LSB);

endmodule
